// File: rtl/moore_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : moore_pkg
//  Description : Shared types and constants for the moore 1101 sequence
//                detector: state enumeration with fixed 3-bit encodings and
//                the progress codes reported on y.
//  Revision    : 1.0  initial release
// ============================================================================
package moore_pkg;

    // Each name records how much of "1101" the most recent input has matched.
    typedef enum logic [2:0] {
        IDLE = 3'd0,  // no useful prefix
        S1   = 3'd1,  // seen "1"
        S11  = 3'd2,  // seen "11"
        S110 = 3'd3,  // seen "110"
        DET  = 3'd4   // seen "1101"
    } state_t;

    // Progress codes driven on y.
    localparam logic [1:0] Y_NONE  = 2'b00;
    localparam logic [1:0] Y_TWO   = 2'b01;
    localparam logic [1:0] Y_THREE = 2'b10;
    localparam logic [1:0] Y_MATCH = 2'b11;

endpackage : moore_pkg
`default_nettype wire

// File: rtl/moore.sv
`default_nettype none
// ============================================================================
//  Module      : moore
//  Description : Moore FSM that detects the serial pattern 1101 on x, one bit
//                per rising clk edge. y reports match progress and is decoded
//                from the state register only (no path from x to y).
//  Ports       : clk - system clock, rising edge active
//                rst - synchronous reset, active-high, dominates x
//                x   - serial data bit
//                y   - [1:0] progress: 00 none/"1", 01 "11", 10 "110",
//                      11 "1101" just completed
//  Options     : MOORE_OVERLAP_EN - when defined, a completed match may share
//                its trailing '1' with the next match (1101101 detects twice).
//                When undefined, detection restarts after each match.
//  Revision    : 1.0  initial release
// ============================================================================
module moore
    import moore_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       x,
    output logic [1:0] y
);

    state_t r_state;
    state_t w_next;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = x ? S1   : IDLE;
            S1:      w_next = x ? S11  : IDLE;
            // Further 1s still leave "11" as the useful suffix.
            S11:     w_next = x ? S11  : S110;
            S110:    w_next = x ? DET  : IDLE;
`ifdef MOORE_OVERLAP_EN
            // The matched trailing '1' plus the new '1' already form "11".
            DET:     w_next = x ? S11  : IDLE;
`else
            // Matched bits are consumed; the new '1' starts a fresh prefix.
            DET:     w_next = x ? S1   : IDLE;
`endif
            // Illegal encodings recover to IDLE on the next edge.
            default: w_next = IDLE;
        endcase
    end

    // Output decode from the state register alone.
    always_comb begin
        y = Y_NONE;
        case (r_state)
            IDLE:    y = Y_NONE;
            S1:      y = Y_NONE;
            S11:     y = Y_TWO;
            S110:    y = Y_THREE;
            DET:     y = Y_MATCH;
            default: y = Y_NONE;
        endcase
    end

endmodule : moore
`default_nettype wire

// File: tb/tb_moore.sv
`default_nettype none
// ============================================================================
//  Module      : tb_moore
//  Description : Self-checking bench for moore. Directed scenarios plus a
//                randomized stream, all compared with a reference model that
//                finds the longest suffix of the received bits that is a
//                prefix of 1101.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_moore;

    logic       clk;
    logic       rst;
    logic       x;
    logic [1:0] y;

    int checks   = 0;
    int failures = 0;

    // Reference model state: bits received since the last restart point.
    bit hist[$];
    bit matched = 1'b0;
    bit pat[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};

    moore dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .y   (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Progress code = length of longest suffix of hist matching a prefix of 1101.
    function automatic logic [1:0] model_y();
        int best = 0;
        int n = hist.size();
        for (int len = 1; len <= 4 && len <= n; len++) begin
            bit ok = 1'b1;
            for (int k = 0; k < len; k++) begin
                if (hist[n - len + k] != pat[k]) ok = 1'b0;
            end
            if (ok) best = len;
        end
        case (best)
            2:       return 2'b01;
            3:       return 2'b10;
            4:       return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_update(input bit b, input bit r);
        if (r) begin
            hist.delete();
            matched = 1'b0;
        end else begin
`ifndef MOORE_OVERLAP_EN
            if (matched) hist.delete();
`endif
            hist.push_back(b);
            if (hist.size() > 4) void'(hist.pop_front());
            matched = (model_y() == 2'b11);
        end
    endtask

    // Apply one bit (and rst) for one edge, then settle past the edge.
    task automatic drive(input logic b, input logic r);
        x   = b;
        rst = r;
        @(posedge clk);
        #1;
        model_update(b, r);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(logic'(i[0] ^ 1), 1'b1);
            checks++;
            if (y !== 2'b00) begin
                failures++;
                $display("FAIL reset_cycle%0d: y=%b expected 00", i, y);
            end
        end
        drive(1'b0, 1'b0);
        checks++;
        if (y !== 2'b00) begin
            failures++;
            $display("FAIL reset_release: y=%b expected 00", y);
        end
    endtask

    task automatic test_basic();
        logic       xs [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0] ex [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        drive(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(xs[i], 1'b0);
            checks++;
            if (y !== ex[i] || y !== model_y()) begin
                failures++;
                $display("FAIL basic_step%0d: y=%b expected %b", i, y, ex[i]);
            end
        end
    endtask

    task automatic test_overlap();
        logic       xs [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
`ifdef MOORE_OVERLAP_EN
        logic [1:0] ex [7] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11};
`else
        logic [1:0] ex [7] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};
`endif
        drive(1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            drive(xs[i], 1'b0);
            checks++;
            if (y !== ex[i] || y !== model_y()) begin
                failures++;
                $display("FAIL overlap_step%0d: y=%b expected %b", i, y, ex[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        // 1101 1101 detects twice in both builds.
        logic       xs [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [1:0] ex [8];
        drive(1'b0, 1'b1);
        ex = '{2'b00, 2'b01, 2'b10, 2'b11,
`ifdef MOORE_OVERLAP_EN
               2'b01, 2'b01, 2'b10, 2'b11};
`else
               2'b00, 2'b01, 2'b10, 2'b11};
`endif
        for (int i = 0; i < 8; i++) begin
            drive(xs[i], 1'b0);
            checks++;
            if (y !== ex[i] || y !== model_y()) begin
                failures++;
                $display("FAIL b2b_step%0d: y=%b expected %b", i, y, ex[i]);
            end
        end
    endtask

    task automatic test_long_ones();
        logic       xs [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [1:0] ex [6] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11};
        drive(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive(xs[i], 1'b0);
            checks++;
            if (y !== ex[i] || y !== model_y()) begin
                failures++;
                $display("FAIL ones_step%0d: y=%b expected %b", i, y, ex[i]);
            end
        end
    endtask

    task automatic test_alternating();
        drive(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            drive(logic'(i[0]), 1'b0);
            checks++;
            if (y !== 2'b00) begin
                failures++;
                $display("FAIL alt_step%0d: y=%b expected 00", i, y);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic       xs [3] = '{1'b1, 1'b1, 1'b0};
        logic [1:0] ex [3] = '{2'b00, 2'b01, 2'b10};
        drive(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(xs[i], 1'b0);
            checks++;
            if (y !== ex[i]) begin
                failures++;
                $display("FAIL midrst_pre%0d: y=%b expected %b", i, y, ex[i]);
            end
        end
        drive(1'b1, 1'b1);
        checks++;
        if (y !== 2'b00) begin
            failures++;
            $display("FAIL midrst_reset: y=%b expected 00", y);
        end
        drive(1'b1, 1'b0);
        checks++;
        if (y !== 2'b00) begin
            failures++;
            $display("FAIL midrst_after: y=%b expected 00", y);
        end
        // Second '1' proves the first landed in S1 (progress "11").
        drive(1'b1, 1'b0);
        checks++;
        if (y !== 2'b01) begin
            failures++;
            $display("FAIL midrst_s1: y=%b expected 01", y);
        end
    endtask

    task automatic test_random();
        drive(1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            logic b;
            logic r;
            // Bias towards 1s so partial and full matches occur often.
            b = ($urandom_range(0, 9) < 6);
            r = ($urandom_range(0, 39) == 0);
            drive(b, r);
            checks++;
            if (y !== model_y()) begin
                failures++;
                $display("FAIL random_step%0d: x=%b rst=%b y=%b expected %b",
                         i, b, r, y, model_y());
            end
        end
    endtask

    initial begin
        x   = 1'b0;
        rst = 1'b1;
        test_reset();
        test_basic();
        test_overlap();
        test_back_to_back();
        test_long_ones();
        test_alternating();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_moore
`default_nettype wire
